lsu_mem_stage: RTL and testbench



---
 rtl/lsu_mem_stage_if.sv | 30 +++
 rtl/lsu_mem_stage.sv | 164 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-memory bus between the load/store stage and the memory.
interface lsu_mem_stage_if;
  logic        mem_req_w_o;
  logic        mem_we_w_o;
  logic [31:0] mem_addr_w_o;
  logic [3:0]  mem_be_w_o;
  logic [31:0] mem_wdata_w_o;
  logic        mem_ack_w_i;
  logic [31:0] mem_rdata_w_i;

  modport master (
    output mem_req_w_o,
    output mem_we_w_o,
    output mem_addr_w_o,
    output mem_be_w_o,
    output mem_wdata_w_o,
    input  mem_ack_w_i,
    input  mem_rdata_w_i
  );

  modport slave (
    input  mem_req_w_o,
    input  mem_we_w_o,
    input  mem_addr_w_o,
    input  mem_be_w_o,
    input  mem_wdata_w_o,
    output mem_ack_w_i,
    output mem_rdata_w_i
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// RV32 load/store stage: one bus transaction per request, with lane steering,
// load extension, alignment/legality checks and an optional ack timeout.
module lsu_mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                 clk_w_i,
  input  logic                 rst_w_i,
  input  logic                 start_w_i,
  input  logic                 load_w_i,
  input  logic                 store_w_i,
  input  logic [2:0]           funct3_w_i,
  input  logic [31:0]          alu_res_w_i,
  input  logic [31:0]          store_data_w_i,
  output logic                 busy_w_o,
  output logic                 done_w_o,
  output logic                 fault_w_o,
  output logic [31:0]          load_data_w_o,
  lsu_mem_stage_if.master      mem
);

  localparam int unsigned CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic [CNT_W-1:0]   wait_cnt;

  logic               req_bad;
  logic [3:0]         req_be;
  logic [31:0]        req_wdata;
  logic [15:0]        ld_lane;
  logic [31:0]        ld_ext;

  // Request decode: legality, alignment and store lane steering.
  always_comb begin
    req_bad   = 1'b0;
    req_be    = 4'b1111;
    req_wdata = 32'h0;
    if (load_w_i == store_w_i) begin
      req_bad = 1'b1;
    end
    case (funct3_w_i)
      3'b000, 3'b010: ;
      3'b001: if (alu_res_w_i[0]) req_bad = 1'b1;
      3'b100: if (store_w_i) req_bad = 1'b1;
      3'b101: if (store_w_i || alu_res_w_i[0]) req_bad = 1'b1;
      default: req_bad = 1'b1;
    endcase
    if (funct3_w_i == 3'b010 && alu_res_w_i[1:0] != 2'b00) begin
      req_bad = 1'b1;
    end
    if (store_w_i) begin
      case (funct3_w_i[1:0])
        2'b00: begin
          req_be    = 4'b0001 << alu_res_w_i[1:0];
          req_wdata = {4{store_data_w_i[7:0]}};
        end
        2'b01: begin
          req_be    = 4'b0011 << alu_res_w_i[1:0];
          req_wdata = {2{store_data_w_i[15:0]}};
        end
        default: begin
          req_be    = 4'b1111;
          req_wdata = store_data_w_i;
        end
      endcase
    end
  end

  // Load data: select the addressed lane and extend per funct3.
  always_comb begin
    ld_lane = 16'(mem.mem_rdata_w_i >> {off_q, 3'b000});
    case (funct3_q)
      3'b000:  ld_ext = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b100:  ld_ext = {24'h0, ld_lane[7:0]};
      3'b001:  ld_ext = {{16{ld_lane[15]}}, ld_lane};
      3'b101:  ld_ext = {16'h0, ld_lane};
      default: ld_ext = mem.mem_rdata_w_i;
    endcase
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_w_i or posedge rst_w_i) begin
    if (rst_w_i) begin
      state             <= ST_IDLE;
      funct3_q          <= 3'b000;
      off_q             <= 2'b00;
      wait_cnt          <= '0;
      busy_w_o          <= 1'b0;
      done_w_o          <= 1'b0;
      fault_w_o         <= 1'b0;
      load_data_w_o     <= 32'h0;
      mem.mem_req_w_o   <= 1'b0;
      mem.mem_we_w_o    <= 1'b0;
      mem.mem_addr_w_o  <= 32'h0;
      mem.mem_be_w_o    <= 4'b0000;
      mem.mem_wdata_w_o <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_w_o  <= 1'b0;
          fault_w_o <= 1'b0;
          if (start_w_i) begin
            funct3_q <= funct3_w_i;
            off_q    <= alu_res_w_i[1:0];
            busy_w_o <= 1'b1;
            if (req_bad) begin
              state     <= ST_RESP;
              done_w_o  <= 1'b1;
              fault_w_o <= 1'b1;
            end else begin
              state             <= ST_WAIT;
              wait_cnt          <= '0;
              mem.mem_req_w_o   <= 1'b1;
              mem.mem_we_w_o    <= store_w_i;
              mem.mem_addr_w_o  <= {alu_res_w_i[31:2], 2'b00};
              mem.mem_be_w_o    <= req_be;
              mem.mem_wdata_w_o <= req_wdata;
            end
          end
        end
        ST_WAIT: begin
          if (mem.mem_ack_w_i) begin
            if (!mem.mem_we_w_o) begin
              load_data_w_o <= ld_ext;
            end
            state           <= ST_RESP;
            mem.mem_req_w_o <= 1'b0;
            done_w_o        <= 1'b1;
            fault_w_o       <= 1'b0;
          end else if (TIMEOUT > 0 && wait_cnt == CNT_W'(CNT_LAST)) begin
            state           <= ST_RESP;
            mem.mem_req_w_o <= 1'b0;
            done_w_o        <= 1'b1;
            fault_w_o       <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          state     <= ST_IDLE;
          busy_w_o  <= 1'b0;
          done_w_o  <= 1'b0;
          fault_w_o <= 1'b0;
        end
        default: begin
          state           <= ST_IDLE;
          busy_w_o        <= 1'b0;
          done_w_o        <= 1'b0;
          fault_w_o       <= 1'b0;
          mem.mem_req_w_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Scoreboard bench for lsu_mem_stage: directed requests, a memory responder
// that checks bus fields, and a completion monitor.
module tb_lsu_mem_stage;

  localparam int unsigned TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ld = 1'b0;
  logic        st = 1'b0;
  logic [2:0]  f3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] sdata = 32'h0;
  logic        busy, done, fault;
  logic [31:0] ldata;

  lsu_mem_stage_if mem_bus ();

  lsu_mem_stage #(.TIMEOUT(TMO)) dut (
    .clk_w_i        (clk),
    .rst_w_i        (rst),
    .start_w_i      (start),
    .load_w_i       (ld),
    .store_w_i      (st),
    .funct3_w_i     (f3),
    .alu_res_w_i    (addr),
    .store_data_w_i (sdata),
    .busy_w_o       (busy),
    .done_w_o       (done),
    .fault_w_o      (fault),
    .load_data_w_o  (ldata),
    .mem            (mem_bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fault;
    logic [31:0] data;
    int          done_cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    int          ack_at;
    int          nreq;
    logic [31:0] rdata;
  } bus_t;

  exp_t exp_q[$];
  bus_t bus_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  logic [31:0] last_ld = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Completion monitor: every done pops one expected response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("fault", 32'(fault), 32'(e.fault));
          check("load_data", ldata, e.data);
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("req_low_at_done", 32'(mem_bus.mem_req_w_o), 32'd0);
          check("busy_at_done", 32'(busy), 32'd1);
        end
      end
    end
  end

  // Memory responder: checks the bus request, acks on the scheduled req cycle.
  initial begin
    bus_t cur;
    bit   active = 1'b0;
    int   seen = 0;
    mem_bus.mem_ack_w_i   = 1'b0;
    mem_bus.mem_rdata_w_i = 32'h0;
    cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, ack_at: 0, nreq: -1, rdata: 32'h0};
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        mem_bus.mem_ack_w_i = 1'b0;
      end else if (mem_bus.mem_req_w_o) begin
        if (!active) begin
          active = 1'b1;
          seen = 0;
          if (bus_q.size() == 0) begin
            check("unexpected_req", 32'd1, 32'd0);
            cur = '{addr: 32'h0, be: 4'h0, we: 1'b0, wdata: 32'h0, ack_at: 1, nreq: -1, rdata: 32'h0};
          end else begin
            cur = bus_q.pop_front();
            check("mem_addr", mem_bus.mem_addr_w_o, cur.addr);
            check("mem_be", 32'(mem_bus.mem_be_w_o), 32'(cur.be));
            check("mem_we", 32'(mem_bus.mem_we_w_o), 32'(cur.we));
            if (cur.we) check("mem_wdata", mem_bus.mem_wdata_w_o, cur.wdata);
          end
        end
        seen++;
        if (seen == cur.ack_at) begin
          mem_bus.mem_ack_w_i   = 1'b1;
          mem_bus.mem_rdata_w_i = cur.rdata;
        end else begin
          mem_bus.mem_ack_w_i   = 1'b0;
          mem_bus.mem_rdata_w_i = 32'h5A5A5A5A;
        end
      end else begin
        mem_bus.mem_ack_w_i = 1'b0;
        if (active) begin
          active = 1'b0;
          if (cur.nreq >= 0) check("req_cycles", 32'(seen), 32'(cur.nreq));
        end
      end
    end
  end

  // Issue one request, queue its expectations, and wait until the stage is idle.
  task automatic issue(input logic l, input logic s, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] d,
                       input bit has_bus, input logic [3:0] be, input logic [31:0] wd,
                       input int ack_at, input logic [31:0] rd,
                       input logic flt, input logic [31:0] exp_data, input int lat,
                       input bit poke_busy);
    bus_t b;
    exp_t e;
    bit   idle;
    if (has_bus) begin
      b = '{addr: {a[31:2], 2'b00}, be: be, we: s, wdata: wd, ack_at: ack_at,
            nreq: (ack_at > 0) ? ack_at : int'(TMO), rdata: rd};
      bus_q.push_back(b);
    end
    @(negedge clk);
    e = '{fault: flt, data: exp_data, done_cyc: cyc + lat};
    exp_q.push_back(e);
    start = 1'b1; ld = l; st = s; f3 = fn; addr = a; sdata = d;
    @(negedge clk);
    start = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (poke_busy && i == 0) begin
        start = 1'b1; ld = 1'b0; st = 1'b1; f3 = 3'b010; addr = 32'h500; sdata = 32'hBAD0BAD0;
      end else begin
        start = 1'b0;
      end
      if (!busy) begin
        idle = 1'b1;
        break;
      end
    end
    start = 1'b0;
    if (!idle) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_load_data", ldata, 32'h0);
    check("rst_mem_req", 32'(mem_bus.mem_req_w_o), 32'd0);
    rst = 1'b0;

    // LW 0x100, ack on cycle 3
    last_ld = 32'hDEADBEEF;
    issue(1, 0, 3'b010, 32'h100, 0, 1, 4'hF, 0, 3, 32'hDEADBEEF, 0, last_ld, 4, 0);
    // LB / LBU 0x103
    last_ld = 32'hFFFFFF80;
    issue(1, 0, 3'b000, 32'h103, 0, 1, 4'hF, 0, 1, 32'h80FF0011, 0, last_ld, 2, 0);
    last_ld = 32'h00000080;
    issue(1, 0, 3'b100, 32'h103, 0, 1, 4'hF, 0, 1, 32'h80FF0011, 0, last_ld, 2, 0);
    // SH 0x202, immediate ack
    issue(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 1, 4'b1100, 32'hABCDABCD, 1, 0, 0, last_ld, 2, 0);
    // Faults from IDLE
    issue(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    issue(1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    issue(0, 1, 3'b100, 32'h100, 32'h55, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    issue(0, 0, 3'b000, 32'h100, 0, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    issue(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    issue(1, 0, 3'b001, 32'h103, 0, 0, 0, 0, 0, 0, 1, last_ld, 1, 0);
    // Timeout with no ack; a start while busy is ignored
    issue(1, 0, 3'b010, 32'h300, 0, 1, 4'hF, 0, 0, 0, 1, last_ld, 5, 1);
    // Ack on the final counted cycle beats the timeout
    last_ld = 32'hFFFF8001;
    issue(1, 0, 3'b001, 32'h302, 0, 1, 4'hF, 0, 4, 32'h80010000, 0, last_ld, 5, 0);
    last_ld = 32'h0000F00D;
    issue(1, 0, 3'b101, 32'h300, 0, 1, 4'hF, 0, 2, 32'h1234F00D, 0, last_ld, 3, 0);
    // SB and SW
    issue(0, 1, 3'b000, 32'h101, 32'h000000A5, 1, 4'b0010, 32'hA5A5A5A5, 1, 0, 0, last_ld, 2, 0);
    issue(0, 1, 3'b010, 32'h40, 32'hCAFEF00D, 1, 4'hF, 32'hCAFEF00D, 2, 0, 0, last_ld, 3, 0);

    // Reset in the middle of WAIT
    bus_q.push_back('{addr: 32'h100, be: 4'hF, we: 1'b0, wdata: 32'h0, ack_at: 0, nreq: -1, rdata: 32'h0});
    @(negedge clk);
    start = 1'b1; ld = 1'b1; st = 1'b0; f3 = 3'b010; addr = 32'h100;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_req", 32'(mem_bus.mem_req_w_o), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_load_data", ldata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    last_ld = 32'h11223344;
    issue(1, 0, 3'b010, 32'h100, 0, 1, 4'hF, 0, 1, 32'h11223344, 0, last_ld, 2, 0);

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("bus_q_empty", 32'(bus_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
